normalize_seq: RTL and testbench

Iterative post-add normalizer for the single-precision add/sub datapath. It sits directly upstream of the rounding stage. It takes the raw 27-bit adder sum (carry bit, 23-bit fraction with hidden bit, guard/round bits) plus exponent, sign, sticky (`loss`) and operator. It produces a normalized `{exp, mantis[25:0], loss}` triple in the exact format the rounder consumes. Normalization is done one bit position per clock, behind a valid/ready handshake on both sides.

---
 rtl/normalize_seq.sv | 127 ++++++++++++
 tb/tb_normalize_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/normalize_seq.sv
// normalize_seq: iterative post-add normalizer, one bit position per clock,
// valid/ready on both sides. Rev 1.0
`default_nettype none

module normalize_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [26:0] in_mantis,
  input  logic        in_loss,
  input  logic        in_operator,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic        out_operator,
  output logic [7:0]  out_exp,
  output logic [25:0] out_mantis,
  output logic        out_loss,
  output logic        out_overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_exp, w_exp_nxt;
  logic [26:0] r_man, w_man_nxt;
  logic        r_loss, w_loss_nxt;
  logic        r_ovf, w_ovf_nxt;
  logic        r_sign, w_sign_nxt;
  logic        r_op, w_op_nxt;
  logic [7:0]  w_exp_inc;

  assign w_exp_inc = r_exp + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_exp   <= 8'd0;
      r_man   <= 27'd0;
      r_loss  <= 1'b0;
      r_ovf   <= 1'b0;
      r_sign  <= 1'b0;
      r_op    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_exp   <= w_exp_nxt;
      r_man   <= w_man_nxt;
      r_loss  <= w_loss_nxt;
      r_ovf   <= w_ovf_nxt;
      r_sign  <= w_sign_nxt;
      r_op    <= w_op_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    w_man_nxt   = r_man;
    w_loss_nxt  = r_loss;
    w_ovf_nxt   = r_ovf;
    w_sign_nxt  = r_sign;
    w_op_nxt    = r_op;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_exp_nxt   = in_exp;
          w_man_nxt   = in_mantis;
          w_loss_nxt  = in_loss;
          w_ovf_nxt   = 1'b0;
          w_sign_nxt  = in_sign;
          w_op_nxt    = in_operator;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_state_nxt = S_DONE;
        // Left shifts only lower the exponent, so 8'hFF here means the
        // operand was loaded as inf/NaN.
        if (r_exp == 8'hFF) begin
          w_exp_nxt = r_exp;
        end else if (r_man == 27'd0) begin
          w_exp_nxt = 8'd0;
        end else if (r_man[26]) begin
          w_man_nxt  = {1'b0, r_man[26:1]};
          w_loss_nxt = r_loss | r_man[0];
          w_exp_nxt  = w_exp_inc;
          if (w_exp_inc == 8'hFF) begin
            w_man_nxt  = 27'd0;
            w_loss_nxt = 1'b0;
            w_ovf_nxt  = 1'b1;
          end
        end else if (r_man[25]) begin
          w_exp_nxt = r_exp;
        end else if (r_exp <= 8'd1) begin
          w_exp_nxt = 8'd0;
        end else begin
          w_man_nxt   = {r_man[25:0], 1'b0};
          w_exp_nxt   = r_exp - 8'd1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign in_ready     = (r_state == S_IDLE);
  assign out_valid    = (r_state == S_DONE);
  assign out_sign     = r_sign;
  assign out_operator = r_op;
  assign out_exp      = r_exp;
  assign out_mantis   = r_man[25:0];
  assign out_loss     = r_loss;
  assign out_overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_normalize_seq.sv
// tb_normalize_seq: directed vectors with literal expectations plus a
// cycle-by-cycle comparison against a leading-zero based reference model.
`default_nettype none

module tb_normalize_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = 8'd0;
  logic [26:0] in_mantis = 27'd0;
  logic        in_loss = 1'b0;
  logic        in_operator = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign, out_operator, out_loss, out_overflow;
  logic [7:0]  out_exp;
  logic [25:0] out_mantis;

  normalize_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mantis(in_mantis),
    .in_loss(in_loss), .in_operator(in_operator),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_operator(out_operator),
    .out_exp(out_exp), .out_mantis(out_mantis),
    .out_loss(out_loss), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  e;
    logic [25:0] m;
    logic        l;
    logic        o;
    logic        s;
    logic        op;
    int          lat;
  } res_t;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc = 0;
  bit   pending = 1'b0;
  bit   prev_v = 1'b0;
  res_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: count leading zeros below the hidden bit and clamp the
  // shift count by how far the exponent can fall before reaching 1.
  function automatic res_t model(input logic s, input logic op, input logic [7:0] e,
                                 input logic [26:0] m, input logic l);
    res_t r;
    int msb, lz, k;
    logic [26:0] sh;
    r.s = s; r.op = op; r.l = l; r.o = 1'b0; r.lat = 1; r.e = e; r.m = m[25:0];
    if (e == 8'hFF) begin
      r.e = e;
    end else if (m == 27'd0) begin
      r.e = 8'd0; r.m = 26'd0;
    end else if (m[26]) begin
      if (e == 8'hFE) begin
        r.e = 8'hFF; r.m = 26'd0; r.l = 1'b0; r.o = 1'b1;
      end else begin
        r.e = e + 8'd1; r.m = m[26:1]; r.l = l | m[0];
      end
    end else begin
      msb = 0;
      for (int i = 0; i < 26; i++) if (m[i]) msb = i;
      lz = 25 - msb;
      k = (int'(e) > 1) ? ((lz < int'(e) - 1) ? lz : int'(e) - 1) : 0;
      sh = m << k;
      r.m = sh[25:0];
      r.e = (k == lz) ? 8'(int'(e) - k) : 8'd0;
      r.lat = k + 1;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && pending) begin
      if (out_valid) begin
        chk("mdl_exp", 32'(out_exp), 32'(cur.e));
        chk("mdl_mantis", 32'(out_mantis), 32'(cur.m));
        chk("mdl_loss", 32'(out_loss), 32'(cur.l));
        chk("mdl_ovf", 32'(out_overflow), 32'(cur.o));
        chk("mdl_sign", 32'(out_sign), 32'(cur.s));
        chk("mdl_op", 32'(out_operator), 32'(cur.op));
        chk("in_ready_done", 32'(in_ready), 32'd0);
        if (!prev_v) chk("mdl_latency", 32'(cyc - acc), 32'(cur.lat));
      end else begin
        chk("in_ready_busy", 32'(in_ready), 32'd0);
      end
    end
    prev_v = out_valid;
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("wait_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic accept(input logic s, input logic op, input logic [7:0] e,
                        input logic [26:0] m, input logic l);
    wait_idle();
    in_sign = s; in_operator = op; in_exp = e; in_mantis = m; in_loss = l;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cur = model(s, op, e, m, l);
    acc = cyc;
    pending = 1'b1;
  endtask

  task automatic run_op(input logic s, input logic op, input logic [7:0] e,
                        input logic [26:0] m, input logic l, input int hold,
                        input logic [7:0] xe, input logic [25:0] xm,
                        input logic xl, input logic xo, input int xlat);
    int n = 0;
    accept(s, op, e, m, l);
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", 32'(out_valid), 32'd1);
      pending = 1'b0;
      return;
    end
    chk("lit_exp", 32'(out_exp), 32'(xe));
    chk("lit_mantis", 32'(out_mantis), 32'(xm));
    chk("lit_loss", 32'(out_loss), 32'(xl));
    chk("lit_ovf", 32'(out_overflow), 32'(xo));
    chk("lit_latency", 32'(cyc - acc), 32'(xlat));
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    pending = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_exp", 32'(out_exp), 32'd0);
    chk("rst_out_mantis", 32'(out_mantis), 32'd0);
    chk("rst_out_flags", {28'd0, out_loss, out_sign, out_operator, out_overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //     s  op  exp    mantis        loss hold  exp    mantis       loss ovf lat
    run_op(0, 0, 8'h80, 27'h2000000, 0,   0,   8'h80, 26'h2000000, 0,   0,  1);
    run_op(0, 0, 8'h7F, 27'h4000001, 0,   0,   8'h80, 26'h2000000, 1,   0,  1);
    run_op(1, 1, 8'h85, 27'h0000100, 0,   5,   8'h74, 26'h2000000, 0,   0,  18);
    run_op(0, 1, 8'h03, 27'h0000100, 0,   0,   8'h00, 26'h0000400, 0,   0,  3);
    run_op(1, 0, 8'h40, 27'h0000000, 1,   1,   8'h00, 26'h0000000, 1,   0,  1);
    run_op(0, 0, 8'hFE, 27'h4000000, 1,   0,   8'hFF, 26'h0000000, 0,   1,  1);
    run_op(0, 0, 8'hFF, 27'h0000000, 0,   0,   8'hFF, 26'h0000000, 0,   0,  1);
    run_op(1, 1, 8'hFF, 27'h0400001, 1,   2,   8'hFF, 26'h0400001, 1,   0,  1);
    run_op(0, 0, 8'h01, 27'h1000000, 0,   0,   8'h00, 26'h1000000, 0,   0,  1);
    run_op(0, 1, 8'h02, 27'h1000000, 0,   0,   8'h01, 26'h2000000, 0,   0,  2);
    run_op(1, 0, 8'h80, 27'h0000001, 1,   3,   8'h67, 26'h2000000, 1,   0,  26);
    run_op(1, 1, 8'h10, 27'h7FFFFFF, 0,   0,   8'h11, 26'h3FFFFFF, 1,   0,  1);

    // Asynchronous reset in the middle of a long shift sequence.
    accept(0, 1, 8'h85, 27'h0000100, 1);
    repeat (5) @(negedge clk);
    pending = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_out_exp", 32'(out_exp), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 0, 8'h90, 27'h0800000, 1,   0,   8'h8E, 26'h2000000, 1,   0,  3);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
